// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader,
// plus the CPU hold/status outputs. slave = loader side, master = stream source.
interface imem_loader_if #(
    parameter int PC_SIZE = 8
);
    logic               in_valid;
    logic [7:0]         in_data;
    logic               in_ready;
    logic               wr_en;
    logic [PC_SIZE-1:0] wr_addr;
    logic [7:0]         wr_data;
    logic               cpu_hold;
    logic               load_done;
    logic               load_err;

    modport slave (
        input  in_valid, in_data,
        output in_ready, wr_en, wr_addr, wr_data, cpu_hold, load_done, load_err
    );

    modport master (
        output in_valid, in_data,
        input  in_ready, wr_en, wr_addr, wr_data, cpu_hold, load_done, load_err
    );
endinterface

// File: rtl/imem_loader.sv
// Instruction-memory loader: parses HEADER, N, N payload bytes, XOR checksum
// from a valid/ready byte stream, writes the payload into i_mem, pads the rest
// with FILL_INSTR and keeps the CPU in reset until a good program is resident.
// NOTE: i_mem is an external RAM and is never cleared here; rst only resets the
// control state, so words already written survive a reset.
module imem_loader #(
    parameter int         PC_SIZE    = 8,
    parameter logic [7:0] FILL_INSTR = 8'h00,
    parameter logic [7:0] HEADER     = 8'hA5
) (
    input  logic         clk,
    input  logic         rst,
    imem_loader_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_LEN, S_DATA, S_CSUM, S_FILL, S_DONE
    } state_e;

    // Count is 9 bits so N == DEPTH is representable even with PC_SIZE = 8.
    localparam logic [8:0] DEPTH = 9'(1 << PC_SIZE);
    localparam logic [8:0] LAST  = DEPTH - 9'd1;

    state_e             state_q, state_d;
    logic [8:0]         len_q, len_d;
    logic [8:0]         count_q, count_d;
    logic [7:0]         csum_q, csum_d;
    logic               in_ready_q, in_ready_d;
    logic               wr_en_q, wr_en_d;
    logic [PC_SIZE-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]         wr_data_q, wr_data_d;
    logic               cpu_hold_q, cpu_hold_d;
    logic               load_done_q, load_done_d;
    logic               load_err_q, load_err_d;

    logic       accept;
    logic       is_header;
    logic       len_ok;
    logic       csum_ok;
    logic       release_cpu;
    logic [8:0] count_inc;

    assign accept    = bus.in_valid && in_ready_q;
    assign is_header = (bus.in_data == HEADER);
    assign len_ok    = (bus.in_data != 8'd0) && ({1'b0, bus.in_data} <= DEPTH);
    assign csum_ok   = (bus.in_data == csum_q);
    assign count_inc = count_q + 9'd1;

    // State register.
    // NOTE: clocked blocks use non-blocking assignments so every flop samples
    // the values from before the edge, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic: frame parsing and the fill sweep.
    // NOTE: each combinational output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept && is_header) state_d = S_LEN;
            S_LEN:  if (accept) state_d = len_ok ? S_DATA : S_IDLE;
            S_DATA: if (accept && (count_inc == len_q)) state_d = S_CSUM;
            S_CSUM: begin
                if (accept) begin
                    if (!csum_ok)            state_d = S_IDLE;
                    else if (len_q == DEPTH) state_d = S_DONE;
                    else                     state_d = S_FILL;
                end
            end
            S_FILL: if (count_q == LAST) state_d = S_DONE;
            S_DONE: if (accept && is_header) state_d = S_LEN;
            default: state_d = S_IDLE;
        endcase
    end

    // Output/datapath logic: writes, checksum, counters and status flags.
    always_comb begin
        len_d      = len_q;
        count_d    = count_q;
        csum_d     = csum_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        load_err_d = load_err_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (accept && is_header) load_err_d = 1'b0;
            end
            S_LEN: begin
                if (accept) begin
                    if (len_ok) begin
                        len_d   = {1'b0, bus.in_data};
                        count_d = 9'd0;
                        csum_d  = 8'd0;
                    end else begin
                        load_err_d = 1'b1;
                    end
                end
            end
            S_DATA: begin
                if (accept) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = count_q[PC_SIZE-1:0];
                    wr_data_d = bus.in_data;
                    csum_d    = csum_q ^ bus.in_data;
                    count_d   = count_inc;
                end
            end
            S_CSUM: begin
                if (accept && !csum_ok) load_err_d = 1'b1;
            end
            S_FILL: begin
                // count_q still equals N on entry, so it doubles as the fill address.
                wr_en_d   = 1'b1;
                wr_addr_d = count_q[PC_SIZE-1:0];
                wr_data_d = FILL_INSTR;
                count_d   = count_inc;
            end
            default: ;
        endcase
        // The CPU is released only once in DONE with no write still in flight,
        // i.e. the cycle after the last wr_en pulse.
        release_cpu = (state_d == S_DONE) && !wr_en_d;
        cpu_hold_d  = !release_cpu;
        load_done_d = release_cpu;
        in_ready_d  = (state_d != S_FILL);
    end

    // Datapath and output registers; all outputs come straight from flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_q       <= 9'd0;
            count_q     <= 9'd0;
            csum_q      <= 8'd0;
            in_ready_q  <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= 8'd0;
            cpu_hold_q  <= 1'b1;
            load_done_q <= 1'b0;
            load_err_q  <= 1'b0;
        end else begin
            len_q       <= len_d;
            count_q     <= count_d;
            csum_q      <= csum_d;
            in_ready_q  <= in_ready_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            cpu_hold_q  <= cpu_hold_d;
            load_done_q <= load_done_d;
            load_err_q  <= load_err_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.wr_en     = wr_en_q;
    assign bus.wr_addr   = wr_addr_q;
    assign bus.wr_data   = wr_data_q;
    assign bus.cpu_hold  = cpu_hold_q;
    assign bus.load_done = load_done_q;
    assign bus.load_err  = load_err_q;
endmodule
